// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the dcache request port: the memory command encoding,
// the default request packet layout and the default arbiter sizing.
package dcache_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_TAG_W        = 3;

  // Request packet at the default widths; the top builds the same layout
  // from its own parameters.
  typedef struct packed {
    MEM_COMMAND                cmd;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_DATA_W-1:0]     data;
    logic [1:0]                size;
    logic [DEF_TAG_W-1:0]      tag;
  } DCACHE_REQ_PACKET;

  // Width of a counter that must hold the values 0..limit inclusive.
  function automatic int sat_cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/dcache_req_buffer.sv
// One-entry dcache request buffer with its IDLE/HOLD state machine.
// A captured packet is held unchanged until the cache accepts it; a new
// packet may be loaded on the same edge the old one is accepted.
module dcache_req_buffer
  import dcache_port_arbiter_pkg::*;
#(
  parameter type pkt_t = DCACHE_REQ_PACKET
) (
  input  logic clock,
  input  logic reset,
  input  logic load_en,
  input  pkt_t pkt_in,
  output pkt_t pkt_out,
  output logic valid,
  input  logic accept,
  output logic capture_ok
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0] state_r;
  pkt_t       pkt_r;

  // A new request may enter when empty, or when the held one leaves this edge.
  always_comb begin
    capture_ok = 1'b0;
    if (state_r == ST_IDLE) begin
      capture_ok = 1'b1;
    end else begin
      capture_ok = accept;
    end
  end

  // State and packet register; accept while IDLE is deliberately ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pkt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_en) begin
            state_r <= ST_HOLD;
            pkt_r   <= pkt_in;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (load_en) begin
            state_r <= ST_HOLD;
            pkt_r   <= pkt_in;
          end else if (accept) begin
            state_r <= ST_IDLE;
            pkt_r   <= '0;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          pkt_r   <= '0;
        end
      endcase
    end
  end

  assign valid   = (state_r == ST_HOLD);
  assign pkt_out = pkt_r;

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbiter sharing the single dcache request port between the load unit and
// the store queue drain. Loads normally win; a store wins when the store
// queue is nearly full or after STARVE_LIMIT consecutive lost cycles.
// Optional feature macro: DCACHE_ARB_STATS_EN adds grant/stall counters.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int TAG_W        = DEF_TAG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  input  logic [1:0]        ld_req_size,
  input  logic [TAG_W-1:0]  ld_req_tag,
  output logic              ld_grant,
  input  logic              st_req_valid,
  input  logic [ADDR_W-1:0] st_req_addr,
  input  logic [DATA_W-1:0] st_req_data,
  input  logic [1:0]        st_req_size,
  output logic              st_grant,
  input  logic              sq_almost_full,
  output logic              dc_req_valid,
  output logic [1:0]        dc_req_cmd,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic [DATA_W-1:0] dc_req_data,
  output logic [1:0]        dc_req_size,
  output logic [TAG_W-1:0]  dc_req_tag,
  input  logic              dc_accept
`ifdef DCACHE_ARB_STATS_EN
  ,
  output logic [31:0]       arb_ld_grants,
  output logic [31:0]       arb_st_grants,
  output logic [31:0]       arb_stall_cycles
`endif
);

  localparam int CNT_W = sat_cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    MEM_COMMAND          cmd;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [1:0]          size;
    logic [TAG_W-1:0]    tag;
  } req_pkt_t;

  logic             cap_ok_s;
  logic             ld_win_s;
  logic             st_win_s;
  logic             load_en_s;
  logic             buf_valid_s;
  req_pkt_t         pkt_in_s;
  req_pkt_t         pkt_out_s;
  logic [CNT_W-1:0] starve_cnt_r;

  // Pick at most one winner; nothing is granted during reset or while the
  // buffer is occupied and not being drained.
  always_comb begin
    ld_win_s = 1'b0;
    st_win_s = 1'b0;
    if (reset) begin
      ld_win_s = 1'b0;
      st_win_s = 1'b0;
    end else if (cap_ok_s) begin
      if (st_req_valid && (sq_almost_full || (starve_cnt_r >= STARVE_MAX))) begin
        st_win_s = 1'b1;
      end else if (ld_req_valid) begin
        ld_win_s = 1'b1;
      end else if (st_req_valid) begin
        st_win_s = 1'b1;
      end else begin
        st_win_s = 1'b0;
      end
    end else begin
      ld_win_s = 1'b0;
    end
  end

  // Build the winner's packet: loads carry zero data, stores a zero tag.
  always_comb begin
    pkt_in_s = '0;
    if (st_win_s) begin
      pkt_in_s.cmd  = MEM_STORE;
      pkt_in_s.addr = st_req_addr;
      pkt_in_s.data = st_req_data;
      pkt_in_s.size = st_req_size;
      pkt_in_s.tag  = {TAG_W{1'b0}};
    end else if (ld_win_s) begin
      pkt_in_s.cmd  = MEM_LOAD;
      pkt_in_s.addr = ld_req_addr;
      pkt_in_s.data = {DATA_W{1'b0}};
      pkt_in_s.size = ld_req_size;
      pkt_in_s.tag  = ld_req_tag;
    end else begin
      pkt_in_s = '0;
    end
  end

  assign load_en_s = ld_win_s | st_win_s;
  assign ld_grant  = ld_win_s;
  assign st_grant  = st_win_s;

  // Count consecutive capture opportunities a waiting store has lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (cap_ok_s) begin
      if (st_win_s || !st_req_valid) begin
        starve_cnt_r <= {CNT_W{1'b0}};
      end else if (starve_cnt_r < STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  dcache_req_buffer #(
    .pkt_t (req_pkt_t)
  ) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .load_en    (load_en_s),
    .pkt_in     (pkt_in_s),
    .pkt_out    (pkt_out_s),
    .valid      (buf_valid_s),
    .accept     (dc_accept),
    .capture_ok (cap_ok_s)
  );

  assign dc_req_valid = buf_valid_s;
  assign dc_req_cmd   = pkt_out_s.cmd;
  assign dc_req_addr  = pkt_out_s.addr;
  assign dc_req_data  = pkt_out_s.data;
  assign dc_req_size  = pkt_out_s.size;
  assign dc_req_tag   = pkt_out_s.tag;

`ifdef DCACHE_ARB_STATS_EN
  logic [31:0] ld_grants_r;
  logic [31:0] st_grants_r;
  logic [31:0] stall_cycles_r;

  // Free-running, wrapping grant and stall counters for performance study.
  always_ff @(posedge clock) begin
    if (reset) begin
      ld_grants_r    <= 32'd0;
      st_grants_r    <= 32'd0;
      stall_cycles_r <= 32'd0;
    end else begin
      ld_grants_r    <= ld_grants_r + {31'd0, ld_win_s};
      st_grants_r    <= st_grants_r + {31'd0, st_win_s};
      stall_cycles_r <= stall_cycles_r + {31'd0, (buf_valid_s & ~dc_accept)};
    end
  end

  assign arb_ld_grants    = ld_grants_r;
  assign arb_st_grants    = st_grants_r;
  assign arb_stall_cycles = stall_cycles_r;
`endif

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

- Shares the single data-cache request port between the load unit and the store queue's retirement drain.
- Each cycle it selects at most one requester and captures that request into a one-entry output buffer.
- It holds the buffered request on the dcache port until the cache accepts it.
- It sits between the load buffer / store queue and the dcache. It replaces the direct store-queue-to-dcache packet path with a fair, starvation-bounded arbiter.

## Interface
- STARVE_LIMIT, 4: consecutive lost store cycles before the store request is forced to win.
- ADDR_W, 32: address width.
- DATA_W, 32: store data width.
- TAG_W, 3: load tag width (load buffer index).
- clock  in  1  system clock. One clock domain.
- reset  in  1  synchronous, active-high.
- ld_req_valid  in  1  load request pending.
- ld_req_addr  in  ADDR_W  load address.
- ld_req_size  in  2  byte/half/word.
- ld_req_tag  in  TAG_W  load buffer index, returned with the data.
- ld_grant  out  1  load captured this cycle; requester drops or advances.
- st_req_valid  in  1  oldest retired store ready to write.
- st_req_addr  in  ADDR_W  store address.
- st_req_data  in  DATA_W  store data.
- st_req_size  in  2  store size.
- st_grant  out  1  store captured this cycle; store queue advances its head.
- sq_almost_full  in  1  store queue pressure hint.
- dc_req_valid  out  1  buffered request valid.
- dc_req_cmd  out  2  MEM_NONE / MEM_LOAD / MEM_STORE.
- dc_req_addr  out  ADDR_W  buffered address.
- dc_req_data  out  DATA_W  buffered data; 0 for loads.
- dc_req_size  out  2  buffered size.
- dc_req_tag  out  TAG_W  buffered tag; 0 for stores.
- dc_accept  in  1  dcache takes the buffered request at this edge.

## Operation
- FSM states:
  - IDLE: buffer empty.
  - HOLD: buffer full, dc_req_valid=1.
- Capture is allowed when the state is IDLE, or when it is HOLD and dc_accept=1 (back-to-back transfer).
- Selection, evaluated only when capture is allowed:
  - Store wins if st_req_valid, and either sq_almost_full=1 or starve_cnt ≥ STARVE_LIMIT.
  - Otherwise a valid load wins.
  - Otherwise a valid store wins.
- ld_grant and st_grant are combinational, one-hot or zero, and never asserted when capture is not allowed.
- On a grant the buffer loads the winner's fields and the state becomes HOLD.
- If HOLD with dc_accept=1 and no grant, the state becomes IDLE and the outputs return to reset values.
- Buffered outputs are stable while in HOLD and dc_accept=0. They do not change when the inputs change.
- starve_cnt is ceil(log2(STARVE_LIMIT+1)) bits wide and saturates at STARVE_LIMIT.
  - It increments when st_req_valid=1 and st_grant=0 in a capture-allowed cycle.
  - It clears on st_grant or when st_req_valid=0.
  - It holds in non-capture cycles.
- dc_accept while IDLE is ignored.

## Timing
- Grant and capture happen in the same cycle. The request appears on dc_req_* at the next edge (1-cycle latency).
- Minimum request occupancy is 1 cycle. A sustained throughput of 1 request/cycle is possible when dc_accept is held high.
- Reset values:
  - dc_req_valid=0, dc_req_cmd=MEM_NONE.
  - dc_req_addr, dc_req_data, dc_req_size and dc_req_tag = 0.
  - starve_cnt=0, state IDLE.
  - ld_grant and st_grant are forced to 0 while reset=1.
- Reset mid-HOLD drops the buffered request. Requesters must not treat a pre-reset grant as committed to the cache.

## Configuration
- DCACHE_ARB_STATS_EN defined adds three 32-bit outputs, all reset to 0 and wrapping modulo 2^32:
  - arb_ld_grants: count of ld_grant cycles.
  - arb_st_grants: count of st_grant cycles.
  - arb_stall_cycles: cycles in HOLD with dc_accept=0.
- Without the macro these ports and counters do not exist, and the block behaviour is otherwise identical.

## Structure
- In sys_defs.svh:
  - MEM_COMMAND enum (MEM_NONE/MEM_LOAD/MEM_STORE).
  - DCACHE_REQ_PACKET struct (cmd, addr, data, size, tag).
  - Default STARVE_LIMIT constant.
- The output buffer plus the IDLE/HOLD FSM is the one natural sub-module: dcache_req_buffer, with load_en, packet in, packet out, valid and accept.
- Selection and starve_cnt stay in the top level.

## Test plan
- Reset held 2 cycles with both requests valid:
  - grants=0 and dc_req_valid=0 throughout.
  - After release, the first grant is ld_grant and dc_req_cmd=MEM_LOAD appears the next cycle.
- Load (addr 0x100, tag 5) and store both valid continuously, dc_accept=1:
  - Loads win 4 cycles.
  - The 5th capture is st_grant.
  - starve_cnt returns to 0 and the pattern repeats.
- sq_almost_full=1 with both valid:
  - st_grant in the first capture-allowed cycle.
  - dc_req_data equals st_req_data (0xDEADBEEF).
- Store buffered, dc_accept=0 for 3 cycles while inputs change:
  - Outputs hold and no grants.
  - On the dc_accept cycle, a pending load is granted and appears the next cycle with no bubble.
- Single load, dc_accept pulsed once:
  - State returns IDLE and dc_req_valid=0 the next cycle.
  - dc_accept while IDLE has no effect.
- With DCACHE_ARB_STATS_EN, 3 loads, 1 store and 2 stall cycles give arb_ld_grants=3, arb_st_grants=1 and arb_stall_cycles=2.
